// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch/decode front end:
// opcode encodings, field layout, legality check and FSM states.
package isa_pkg;

   localparam int OPC_W   = 4;
   localparam int REG_W   = 2;
   localparam int OPD_W   = 10;
   localparam int OPC_LSB = 12;
   localparam int REG_LSB = 10;
   localparam int OPD_LSB = 0;

   typedef enum logic [OPC_W-1:0] {
      OP_ADD   = 4'h0,
      OP_SUB   = 4'h1,
      OP_AND   = 4'h2,
      OP_OR    = 4'h3,
      OP_XOR   = 4'h4,
      OP_NOT   = 4'h5,
      OP_LOAD  = 4'h6,
      OP_STORE = 4'h7,
      OP_TEST  = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_HOLD,
      S_HALT
   } state_e;

   // 1000..1110 are reserved and trap the fetch unit
   function automatic logic is_legal(input logic [OPC_W-1:0] op);
      logic ok;
      ok = 1'b0;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
         OP_NOT, OP_LOAD, OP_STORE, OP_TEST: ok = 1'b1;
         default:                            ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter with clear, wrapping increment and hold.
// Hold is the default when neither clr nor inc is asserted.
module program_counter #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              inc,
   output logic [ADDR_W-1:0] pc
);

   logic [ADDR_W-1:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (clr)
         pc_d = '0;
      else if (inc)
         pc_d = pc_q + ADDR_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pc_q <= '0;
      else
         pc_q <= pc_d;
   end

   assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: fetches one word per instruction from
// program memory, splits it into fields and offers them with valid/ready.
module instr_fetch_decode
   import isa_pkg::*;
#(
   parameter int ADDR_W  = 5,
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               run,
   input  logic               halt_clr,
   output logic [ADDR_W-1:0]  instruction_address,
   input  logic [INSTR_W-1:0] instruction,
   output logic               dec_valid,
   input  logic               dec_ready,
   output logic [OPC_W-1:0]   dec_opcode,
   output logic [REG_W-1:0]   dec_reg,
   output logic [OPD_W-1:0]   dec_operand,
   output logic [ADDR_W-1:0]  dec_pc,
   output logic               illegal
);

   state_e             state_q, state_d;
   logic [INSTR_W-1:0] ir_q, ir_d;
   logic               dec_valid_q, dec_valid_d;
   logic [OPC_W-1:0]   dec_opcode_q, dec_opcode_d;
   logic [REG_W-1:0]   dec_reg_q, dec_reg_d;
   logic [OPD_W-1:0]   dec_operand_q, dec_operand_d;
   logic [ADDR_W-1:0]  dec_pc_q, dec_pc_d;
   logic               illegal_q, illegal_d;

   logic               pc_inc;
   logic [ADDR_W-1:0]  pc;
   logic [OPC_W-1:0]   ir_opc;

   assign ir_opc = ir_q[OPC_LSB +: OPC_W];

   program_counter #(
      .ADDR_W (ADDR_W)
   ) u_pc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (1'b0),
      .inc   (pc_inc),
      .pc    (pc)
   );

   always_comb begin
      state_d       = state_q;
      ir_d          = ir_q;
      dec_valid_d   = dec_valid_q;
      dec_opcode_d  = dec_opcode_q;
      dec_reg_d     = dec_reg_q;
      dec_operand_d = dec_operand_q;
      dec_pc_d      = dec_pc_q;
      illegal_d     = illegal_q;
      pc_inc        = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (run)
               state_d = S_FETCH;
         end
         S_FETCH: begin
            ir_d    = instruction;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            if (is_legal(ir_opc)) begin
               dec_opcode_d  = ir_opc;
               dec_reg_d     = ir_q[REG_LSB +: REG_W];
               dec_operand_d = ir_q[OPD_LSB +: OPD_W];
               dec_pc_d      = pc;
               dec_valid_d   = 1'b1;
               pc_inc        = 1'b1;
               state_d       = S_HOLD;
            end else begin
               // pc stays on the offending word until halt_clr
               illegal_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_HOLD: begin
            if (dec_ready) begin
               dec_valid_d = 1'b0;
               state_d     = run ? S_FETCH : S_IDLE;
            end
         end
         S_HALT: begin
            if (halt_clr) begin
               illegal_d = 1'b0;
               pc_inc    = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         ir_q          <= '0;
         dec_valid_q   <= 1'b0;
         dec_opcode_q  <= '0;
         dec_reg_q     <= '0;
         dec_operand_q <= '0;
         dec_pc_q      <= '0;
         illegal_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         ir_q          <= ir_d;
         dec_valid_q   <= dec_valid_d;
         dec_opcode_q  <= dec_opcode_d;
         dec_reg_q     <= dec_reg_d;
         dec_operand_q <= dec_operand_d;
         dec_pc_q      <= dec_pc_d;
         illegal_q     <= illegal_d;
      end
   end

   assign instruction_address = pc;
   assign dec_valid           = dec_valid_q;
   assign dec_opcode          = dec_opcode_q;
   assign dec_reg             = dec_reg_q;
   assign dec_operand         = dec_operand_q;
   assign dec_pc              = dec_pc_q;
   assign illegal             = illegal_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: a program-memory array plus a
// reference pc that walks the memory by the ISA rules.
module tb_instr_fetch_decode;

   localparam int AW = 5;
   localparam int IW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          run;
   logic          halt_clr;
   logic          dec_ready;
   logic [AW-1:0] instruction_address;
   logic [IW-1:0] instruction;
   logic          dec_valid;
   logic [3:0]    dec_opcode;
   logic [1:0]    dec_reg;
   logic [9:0]    dec_operand;
   logic [AW-1:0] dec_pc;
   logic          illegal;

   logic [IW-1:0] mem [32];

   int checks = 0;
   int errors = 0;
   int pc_m   = 0;
   int cyc    = 0;

   assign instruction = mem[instruction_address];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   instr_fetch_decode #(
      .ADDR_W  (AW),
      .INSTR_W (IW)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .run                 (run),
      .halt_clr            (halt_clr),
      .instruction_address (instruction_address),
      .instruction         (instruction),
      .dec_valid           (dec_valid),
      .dec_ready           (dec_ready),
      .dec_opcode          (dec_opcode),
      .dec_reg             (dec_reg),
      .dec_operand         (dec_operand),
      .dec_pc              (dec_pc),
      .illegal             (illegal)
   );

   function automatic logic [15:0] rand_word();
      int         k;
      logic [3:0] op;
      logic [11:0] low;
      k   = $urandom_range(8);
      op  = (k == 8) ? 4'hF : 4'(k);
      low = 12'($urandom_range(4095));
      return {op, low};
   endfunction

   function automatic logic [20:0] exp_fields(input int p);
      logic [15:0] w;
      w = mem[p];
      return {w[15:12], w[11:10], w[9:0], 5'(p)};
   endfunction

   function automatic logic [20:0] got_fields();
      return {dec_opcode, dec_reg, dec_operand, dec_pc};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_mem();
      for (int i = 0; i < 32; i++) mem[i] = rand_word();
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      run       = 1'b0;
      halt_clr  = 1'b0;
      dec_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      pc_m  = 0;
   endtask

   task automatic wait_valid(input int lim, output bit ok);
      int n;
      n = 0;
      while (dec_valid !== 1'b1 && n < lim) begin
         tick();
         n++;
      end
      ok = (dec_valid === 1'b1);
   endtask

   task automatic test_reset();
      fill_mem();
      rst_n     = 1'b0;
      run       = 1'b0;
      halt_clr  = 1'b0;
      dec_ready = 1'b0;
      #3;
      checks++;
      if (dec_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid got=%b want=0", dec_valid);
      end
      checks++;
      if (illegal !== 1'b0) begin
         errors++;
         $display("FAIL reset_illegal got=%b want=0", illegal);
      end
      checks++;
      if (got_fields() !== 21'd0) begin
         errors++;
         $display("FAIL reset_fields got=%h want=0", got_fields());
      end
      checks++;
      if (instruction_address !== 5'd0) begin
         errors++;
         $display("FAIL reset_addr got=%0d want=0", instruction_address);
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      bit ok;
      int t0;
      int seen;
      do_reset();
      fill_mem();
      mem[0] = 16'h0000;
      mem[1] = 16'h6400;
      dec_ready = 1'b1;
      run = 1'b1;
      t0 = cyc;
      for (int k = 0; k < 2; k++) begin
         wait_valid(10, ok);
         checks++;
         if (!ok || cyc - t0 != 3) begin
            errors++;
            $display("FAIL basic_latency%0d got=%0d want=3", k, cyc - t0);
         end
         t0 = cyc;
         checks++;
         if (got_fields() !== exp_fields(pc_m)) begin
            errors++;
            $display("FAIL basic_xfer%0d got=%h want=%h",
                     k, got_fields(), exp_fields(pc_m));
         end
         pc_m = (pc_m + 1) % 32;
         if (k == 1) run = 1'b0;
         tick();
      end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (dec_valid === 1'b1) seen++;
         tick();
      end
      checks++;
      if (seen != 0 || instruction_address !== 5'(pc_m)) begin
         errors++;
         $display("FAIL basic_idle got=%0d/%0d want=0/%0d",
                  seen, instruction_address, pc_m);
      end
   endtask

   task automatic test_backpressure();
      bit          ok;
      int          seen;
      logic [20:0] snap;
      dec_ready = 1'b0;
      run = 1'b1;
      wait_valid(10, ok);
      checks++;
      if (!ok || got_fields() !== exp_fields(pc_m)) begin
         errors++;
         $display("FAIL bp_xfer got=%h want=%h", got_fields(), exp_fields(pc_m));
      end
      snap = exp_fields(pc_m);
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({dec_valid, got_fields(), instruction_address}
             !== {1'b1, snap, 5'(pc_m + 1)}) begin
            errors++;
            $display("FAIL bp_stable%0d got=%b/%h/%0d want=1/%h/%0d",
                     i, dec_valid, got_fields(), instruction_address,
                     snap, (pc_m + 1) % 32);
         end
      end
      dec_ready = 1'b1;
      run = 1'b0;
      tick();
      pc_m = (pc_m + 1) % 32;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (dec_valid === 1'b1) seen++;
         tick();
      end
      checks++;
      if (seen != 0 || instruction_address !== 5'(pc_m)) begin
         errors++;
         $display("FAIL bp_single got=%0d/%0d want=0/%0d",
                  seen, instruction_address, pc_m);
      end
   endtask

   task automatic test_run_drop();
      bit ok;
      int t0;
      int seen;
      dec_ready = 1'b1;
      run = 1'b1;
      t0 = cyc;
      tick();
      run = 1'b0;
      wait_valid(10, ok);
      checks++;
      if (!ok || cyc - t0 != 3 || got_fields() !== exp_fields(pc_m)) begin
         errors++;
         $display("FAIL rundrop_xfer got=%h@%0d want=%h@3",
                  got_fields(), cyc - t0, exp_fields(pc_m));
      end
      pc_m = (pc_m + 1) % 32;
      tick();
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (dec_valid === 1'b1) seen++;
         tick();
      end
      checks++;
      if (seen != 0 || instruction_address !== 5'(pc_m)) begin
         errors++;
         $display("FAIL rundrop_idle got=%0d/%0d want=0/%0d",
                  seen, instruction_address, pc_m);
      end
   endtask

   task automatic test_random_wrap();
      int  xfers;
      int  n;
      int  bad;
      bit  wrapped;
      do_reset();
      fill_mem();
      mem[31] = 16'h7400;
      xfers = 0;
      n = 0;
      bad = 0;
      wrapped = 1'b0;
      while (xfers < 40 && n < 1000) begin
         dec_ready = 1'($urandom_range(1));
         run = ($urandom_range(3) != 0);
         #1;
         if (dec_valid === 1'b1 && dec_ready) begin
            checks++;
            if (got_fields() !== exp_fields(pc_m)) begin
               errors++;
               bad++;
               $display("FAIL rand_xfer%0d got=%h want=%h",
                        xfers, got_fields(), exp_fields(pc_m));
            end
            if (pc_m == 31) begin
               wrapped = 1'b1;
               checks++;
               if ({dec_opcode, dec_reg, dec_pc, instruction_address}
                   !== {4'd7, 2'd1, 5'd31, 5'd0}) begin
                  errors++;
                  $display("FAIL wrap got=%0d/%0d/%0d/%0d want=7/1/31/0",
                           dec_opcode, dec_reg, dec_pc, instruction_address);
               end
            end
            pc_m = (pc_m + 1) % 32;
            xfers++;
         end
         tick();
         n++;
      end
      checks++;
      if (xfers != 40 || !wrapped) begin
         errors++;
         $display("FAIL rand_progress got=%0d wrapped=%0b want=40 wrapped=1",
                  xfers, wrapped);
      end
      run = 1'b0;
      dec_ready = 1'b1;
      tick();
      tick();
   endtask

   task automatic test_illegal();
      int xfers;
      int n;
      bit ok;
      do_reset();
      fill_mem();
      mem[2] = 16'h9000;
      dec_ready = 1'b1;
      run = 1'b1;
      xfers = 0;
      n = 0;
      while (illegal !== 1'b1 && n < 30) begin
         if (dec_valid === 1'b1) begin
            checks++;
            if (got_fields() !== exp_fields(pc_m)) begin
               errors++;
               $display("FAIL ill_pre%0d got=%h want=%h",
                        xfers, got_fields(), exp_fields(pc_m));
            end
            pc_m = (pc_m + 1) % 32;
            xfers++;
         end
         tick();
         n++;
      end
      checks++;
      if (illegal !== 1'b1 || xfers != 2) begin
         errors++;
         $display("FAIL ill_flag got=%b/%0d want=1/2", illegal, xfers);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({dec_valid, illegal, instruction_address} !== {1'b0, 1'b1, 5'd2}) begin
            errors++;
            $display("FAIL ill_halt%0d got=%b/%b/%0d want=0/1/2",
                     i, dec_valid, illegal, instruction_address);
         end
      end
      run = 1'b0;
      halt_clr = 1'b1;
      tick();
      halt_clr = 1'b0;
      checks++;
      if ({dec_valid, illegal, instruction_address} !== {1'b0, 1'b0, 5'd3}) begin
         errors++;
         $display("FAIL ill_clr got=%b/%b/%0d want=0/0/3",
                  dec_valid, illegal, instruction_address);
      end
      halt_clr = 1'b1;
      tick();
      halt_clr = 1'b0;
      tick();
      tick();
      checks++;
      if ({dec_valid, illegal, instruction_address} !== {1'b0, 1'b0, 5'd3}) begin
         errors++;
         $display("FAIL ill_clr_idle got=%b/%b/%0d want=0/0/3",
                  dec_valid, illegal, instruction_address);
      end
      pc_m = 3;
      run = 1'b1;
      wait_valid(10, ok);
      checks++;
      if (!ok || got_fields() !== exp_fields(pc_m)) begin
         errors++;
         $display("FAIL ill_resume got=%h want=%h", got_fields(), exp_fields(pc_m));
      end
      run = 1'b0;
      tick();
   endtask

   task automatic test_reset_hold();
      bit ok;
      do_reset();
      fill_mem();
      dec_ready = 1'b0;
      run = 1'b1;
      tick();
      tick();
      tick();
      tick();
      tick();
      pc_m = 0;
      wait_valid(10, ok);
      rst_n = 1'b0;
      #1;
      checks++;
      if (!ok || dec_valid !== 1'b0 || instruction_address !== 5'd0) begin
         errors++;
         $display("FAIL rst_hold got=%b/%0d want=0/0",
                  dec_valid, instruction_address);
      end
      tick();
      rst_n = 1'b1;
      dec_ready = 1'b1;
      wait_valid(10, ok);
      checks++;
      if (!ok || got_fields() !== exp_fields(0)) begin
         errors++;
         $display("FAIL rst_restart got=%h want=%h", got_fields(), exp_fields(0));
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_run_drop();
      test_random_wrap();
      test_illegal();
      test_reset_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
